// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, RECV, STOP, CHECK} ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = 8;

  // True when data bits plus parity bit have odd weight.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic p);
    return ^{data, p};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Registered first-word-fall-through FIFO; head entry read combinationally from storage.
module ps2_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Pop is evaluated first so a push into a full FIFO succeeds when a pop frees a slot.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem[rd_ptr_q[AW-1:0]];
  end

  // Pointer and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the device clock/data, deserialises 11-bit frames
// and buffers good bytes in a FIFO. Define PS2_PARITY_CHK_EN to reject bad-parity frames.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 3);  // parity is post-start bit 8

  logic [2:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  ps2_state_e      state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            stop_q, stop_d;
  logic            overflow_q, frame_err_q;
  logic            fall, sbit, good, push, set_ovf, err_d, pop, empty, full;
`ifdef PS2_PARITY_CHK_EN
  logic            parity_q, parity_d;
`endif

  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign sbit = data_sync_q[1];
  assign pop  = rx_valid && rx_ready;

  // Two-flop synchronisers; a third clock flop supplies the previous value for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  // Frame FSM next-state, shift register, timeout and CHECK-cycle decisions.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    stop_d    = stop_q;
    push      = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_PARITY_CHK_EN
    parity_d  = parity_q;
    good      = stop_q && odd_parity_ok(shift_q, parity_q);
`else
    good      = stop_q;
`endif
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (fall && !sbit) begin
          state_d   = RECV;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      RECV, STOP: begin
        if (fall) begin
          tmo_d = '0;
          if (state_q == STOP) begin
            stop_d  = sbit;
            state_d = CHECK;
          end else begin
            // Data bits enter at the MSB so d0 ends up at bit 0.
            if (bit_cnt_q < 4'(PS2_DATA_BITS)) shift_d = {sbit, shift_q[7:1]};
`ifdef PS2_PARITY_CHK_EN
            else parity_d = sbit;
`endif
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) state_d = STOP;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CHECK: begin
        tmo_d   = '0;
        push    = good;
        err_d   = !good;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A good byte is lost only if the FIFO stays full through this cycle.
  assign set_ovf = push && full && !pop;

  // FSM and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      stop_q      <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHK_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      stop_q      <= stop_d;
      overflow_q  <= overflow_q | set_ovf;
      frame_err_q <= err_d;
`ifdef PS2_PARITY_CHK_EN
      parity_q    <= parity_d;
`endif
    end
  end

  ps2_sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (rx_data),
    .empty (empty),
    .full  (full)
  );

  assign rx_valid  = !empty;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios then randomized frames,
// compared against a queue-based reference of the receive buffer.
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 10;

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, overflow, frame_err;

  ps2_kbd_rx #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int err_seen = 0, err_long = 0;
  logic err_prev = 1'b0;

  // Reference state: buffered bytes, sticky overflow, expected discarded-frame count.
  logic [7:0] q[$];
  logic       exp_ovf = 1'b0;
  int         exp_err = 0;

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_seen++;
    if (frame_err === 1'b1 && err_prev === 1'b1) err_long++;
    err_prev = frame_err;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                           input int nedges);
    logic [10:0] f;
    f = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      ps2_data = f[i];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
    logic good;
    send_bits(b, par_flip, stop_bit, 11);
`ifdef PS2_PARITY_CHK_EN
    good = stop_bit && !par_flip;
`else
    good = stop_bit;
`endif
    if (!good) exp_err++;
    else if (q.size() < DEPTH) q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, {31'd0, rx_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) check({tag, ".data"}, {24'd0, rx_data}, {24'd0, q[0]});
    check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check({tag, ".errs"}, err_seen, exp_err);
    check({tag, ".pulse"}, err_long, 0);
  endtask

  task automatic pop_check(input string tag);
    check({tag, ".pv"}, {31'd0, rx_valid}, 32'd1);
    check({tag, ".pd"}, {24'd0, rx_data}, {24'd0, q[0]});
    void'(q.pop_front());
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (q.size() != 0) pop_check(tag);
    check({tag, ".empty"}, {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    int npop;
    logic [7:0] b;
    logic stp, flip;

    wait_clk(4);
    check("rst.data", {24'd0, rx_data}, 32'd0);
    check("rst.valid", {31'd0, rx_valid}, 32'd0);
    check("rst.ovf", {31'd0, overflow}, 32'd0);
    check("rst.err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // Single frame, no consumer.
    send_frame(8'h1C, 1'b0, 1'b1);
    check_state("one");
    drain("one");

    // Back-to-back frames popped in order.
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    check_state("three");
    drain("three");

    // Overflow: DEPTH+1 frames, then pop one and push one more.
    for (int i = 0; i < DEPTH + 1; i++) send_frame(8'(8'h60 + i), 1'b0, 1'b1);
    check_state("ovf");
    pop_check("ovf1");
    send_frame(8'h45, 1'b0, 1'b1);
    check_state("ovf2");
    drain("ovf");

    // Bad parity: dropped only when parity checking is built in.
    send_frame(8'h1C, 1'b1, 1'b1);
    check_state("par");
    drain("par");

    // Bad stop bit always discarded.
    send_frame(8'hA5, 1'b0, 1'b0);
    check_state("stop");

    // Timeout mid-frame, then a clean frame.
    send_bits(8'h5A, 1'b0, 1'b1, 5);
    wait_clk(TMO + 20);
    exp_err++;
    check_state("tmo");
    send_frame(8'h29, 1'b0, 1'b1);
    check_state("tmo2");
    drain("tmo");

    // Reset mid-frame with two bytes buffered and overflow set.
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    exp_ovf = 1'b1;
    check("pre_rst.ovf", {31'd0, overflow}, 32'd1);
    send_bits(8'h33, 1'b0, 1'b1, 6);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    q.delete();
    exp_ovf = 1'b0;
    check("post_rst.valid", {31'd0, rx_valid}, 32'd0);
    check("post_rst.ovf", {31'd0, overflow}, 32'd0);
    wait_clk(4);
    send_frame(8'h16, 1'b0, 1'b1);
    check_state("rst16");
    drain("rst16");

    // Randomized frames with occasional bad stop/parity and random consumption.
    for (int i = 0; i < 24; i++) begin
      b    = 8'($urandom);
      stp  = ($urandom_range(0, 7) != 0);
      flip = ($urandom_range(0, 7) == 0);
      send_frame(b, flip, stp);
      check_state("rnd");
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) if (q.size() != 0) pop_check("rnd");
    end
    drain("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
